// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants used by the multiply/divide unit.
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      ITER = 2'd2,
      FIX  = 2'd3
   } md_state_t;

   localparam logic MD_OP_MULT = 1'b0;
   localparam logic MD_OP_DIV  = 1'b1;

   localparam logic [5:0] FUNCT_MULT = 6'h18;
   localparam logic [5:0] FUNCT_DIV  = 6'h1A;

endpackage

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV unit owning the HI/LO registers.
// One shared working register and adder serve both the shift-add and restoring-divide loops.
module mult_div_unit
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned MAG_W = WIDTH + 1;
   localparam int unsigned WRK_W = 2 * WIDTH + 1;
   localparam int unsigned ADD_W = WIDTH + 2;

   md_state_t          state, state_nxt;
   logic               op_q, op_nxt;
   logic [MAG_W-1:0]   mag_a, mag_a_nxt;
   logic [MAG_W-1:0]   mag_b, mag_b_nxt;
   logic               neg_res, neg_res_nxt;
   logic               neg_rem, neg_rem_nxt;
   logic               dz_pend, dz_pend_nxt;
   logic [WRK_W-1:0]   work, work_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               busy_nxt, done_nxt, div_zero_nxt;
   logic [WIDTH-1:0]   hi_nxt, lo_nxt;

   logic [MAG_W-1:0]   abs_a, abs_b;
   logic [MAG_W-1:0]   add_x, add_y;
   logic [ADD_W-1:0]   add_res;
   logic [MAG_W-1:0]   rem_new;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   // Shared adder: add multiplicand (MULT) or subtract divisor via ~b + 1 (DIV)
   always_comb begin
      abs_a = mag_a[WIDTH] ? -mag_a : mag_a;
      abs_b = mag_b[WIDTH] ? -mag_b : mag_b;
      if (op_q == MD_OP_DIV) begin
         add_x = work[2*WIDTH-1:WIDTH-1];
         add_y = ~mag_b;
      end else begin
         add_x = work[2*WIDTH:WIDTH];
         add_y = work[0] ? mag_a : '0;
      end
      add_res = {1'b0, add_x} + {1'b0, add_y} + ADD_W'(op_q);
      rem_new = add_res[WIDTH+1] ? add_res[WIDTH:0] : work[2*WIDTH-1:WIDTH-1];
      prod_fix = neg_res ? -work[2*WIDTH-1:0] : work[2*WIDTH-1:0];
      quo_fix  = neg_res ? -work[WIDTH-1:0] : work[WIDTH-1:0];
      rem_fix  = neg_rem ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt    = state;
      op_nxt       = op_q;
      mag_a_nxt    = mag_a;
      mag_b_nxt    = mag_b;
      neg_res_nxt  = neg_res;
      neg_rem_nxt  = neg_rem;
      dz_pend_nxt  = dz_pend;
      work_nxt     = work;
      cnt_nxt      = cnt;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      div_zero_nxt = div_zero;
      hi_nxt       = hi;
      lo_nxt       = lo;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt    = PREP;
               op_nxt       = op;
               mag_a_nxt    = {a[WIDTH-1], a};
               mag_b_nxt    = {b[WIDTH-1], b};
               div_zero_nxt = 1'b0;
               busy_nxt     = 1'b1;
            end
         end
         PREP: begin
            neg_res_nxt = mag_a[WIDTH] ^ mag_b[WIDTH];
            neg_rem_nxt = mag_a[WIDTH];
            mag_a_nxt   = abs_a;
            mag_b_nxt   = abs_b;
            cnt_nxt     = CNT_W'(WIDTH);
            dz_pend_nxt = (op_q == MD_OP_DIV) && (mag_b == '0);
            if (op_q == MD_OP_DIV) begin
               work_nxt = {MAG_W'(0), abs_a[WIDTH-1:0]};
            end else begin
               work_nxt = {MAG_W'(0), abs_b[WIDTH-1:0]};
            end
            // Divide by zero skips the loop; FIX only reports it
            state_nxt = dz_pend_nxt ? FIX : ITER;
         end
         ITER: begin
            if (op_q == MD_OP_DIV) begin
               work_nxt = {rem_new, work[WIDTH-2:0], add_res[WIDTH+1]};
            end else begin
               work_nxt = {1'b0, add_res[WIDTH:0], work[WIDTH-1:1]};
            end
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_nxt = FIX;
            end
         end
         FIX: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            if (dz_pend) begin
               div_zero_nxt = 1'b1;
            end else if (op_q == MD_OP_DIV) begin
               hi_nxt = rem_fix;
               lo_nxt = quo_fix;
            end else begin
               hi_nxt = prod_fix[2*WIDTH-1:WIDTH];
               lo_nxt = prod_fix[WIDTH-1:0];
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         op_q     <= MD_OP_MULT;
         mag_a    <= '0;
         mag_b    <= '0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         dz_pend  <= 1'b0;
         work     <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         state    <= state_nxt;
         op_q     <= op_nxt;
         mag_a    <= mag_a_nxt;
         mag_b    <= mag_b_nxt;
         neg_res  <= neg_res_nxt;
         neg_rem  <= neg_rem_nxt;
         dz_pend  <= dz_pend_nxt;
         work     <= work_nxt;
         cnt      <= cnt_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         div_zero <= div_zero_nxt;
         hi       <= hi_nxt;
         lo       <= lo_nxt;
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against a scoreboard of expected HI/LO results.
module tb_mult_div_unit;

   localparam int unsigned WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a, b;
   logic             busy, done, div_zero;
   logic [WIDTH-1:0] hi, lo;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } exp_t;

   exp_t sb[$];
   logic [31:0] prev_hi = '0;
   logic [31:0] prev_lo = '0;

   mult_div_unit #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Reference model: 64-bit signed arithmetic, truncating division
   task automatic model(input logic opv, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] ehi, output logic [31:0] elo, output logic edz);
      longint sa, sb_v, p, q, r;
      sa   = longint'($signed(av));
      sb_v = longint'($signed(bv));
      edz  = 1'b0;
      ehi  = prev_hi;
      elo  = prev_lo;
      if (opv == 1'b0) begin
         p   = sa * sb_v;
         ehi = p[63:32];
         elo = p[31:0];
      end else if (bv == 32'h0) begin
         edz = 1'b1;
      end else begin
         q   = sa / sb_v;
         r   = sa % sb_v;
         ehi = r[31:0];
         elo = q[31:0];
      end
   endtask

   task automatic run_op(input string tag, input logic opv, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input int elat, input bit mid_pulse);
      exp_t e;
      exp_t got;
      int   lat;
      bit   busy_ok;
      int   extra;
      e.tag = tag; e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = elat;
      sb.push_back(e);
      if (!edz) begin
         prev_hi = ehi;
         prev_lo = elo;
      end
      @(negedge clk);
      start = 1'b1; op = opv; a = av; b = bv;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      busy_ok = 1'b1;
      while (!done && lat < 100) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (mid_pulse && lat == 10) begin
            start = 1'b1; op = 1'b0; a = 32'h1234_5678; b = 32'h9;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      got = sb.pop_front();
      chk({got.tag, "_lat"}, 64'(lat), 64'(got.lat));
      chk({got.tag, "_busy_during"}, 64'(busy_ok), 64'(1));
      chk({got.tag, "_busy_at_done"}, 64'(busy), 64'(0));
      chk({got.tag, "_hi"}, 64'(hi), 64'(got.hi));
      chk({got.tag, "_lo"}, 64'(lo), 64'(got.lo));
      chk({got.tag, "_dz"}, 64'(div_zero), 64'(got.dz));
      extra = 0;
      repeat (mid_pulse ? 40 : 2) begin
         @(posedge clk); #1;
         if (done === 1'b1) extra++;
      end
      chk({got.tag, "_single_done"}, 64'(extra), 64'(0));
      chk({got.tag, "_hi_hold"}, 64'(hi), 64'(got.hi));
   endtask

   task automatic run_model(input string tag, input logic opv, input logic [31:0] av,
                            input logic [31:0] bv);
      logic [31:0] ehi, elo;
      logic        edz;
      model(opv, av, bv, ehi, elo, edz);
      run_op(tag, opv, av, bv, ehi, elo, edz, edz ? 2 : WIDTH + 2, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      chk("reset_dz",   64'(div_zero), 64'(0));
      chk("reset_hi",   64'(hi), 64'(0));
      chk("reset_lo",   64'(lo), 64'(0));
      @(negedge clk);
      rst = 1'b0;

      run_op("mul_7x6",   1'b0, 32'd7,        32'd6,        32'h0,        32'h2A,       1'b0, 34, 1'b0);
      run_op("mul_m3x5",  1'b0, 32'hFFFF_FFFD, 32'd5,       32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34, 1'b0);
      run_op("mul_min2",  1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,     1'b0, 34, 1'b0);
      run_op("div_m7_2",  1'b1, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 1'b0);
      run_op("mul_pre",   1'b0, 32'd1000,      32'd3,       32'h0,        32'd3000,     1'b0, 34, 1'b0);
      run_op("div_zero",  1'b1, 32'd5,         32'd0,       32'd0,        32'd3000,     1'b1, 2,  1'b0);
      run_op("div_100_m7", 1'b1, 32'd100,      32'hFFFF_FFF9, 32'h2,      32'hFFFF_FFF2, 1'b0, 34, 1'b0);
      run_op("div_ovf",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,      32'h8000_0000, 1'b0, 34, 1'b1);

      for (int i = 0; i < 4; i++) begin
         run_model("mul_rand", 1'b0, $urandom, $urandom);
         run_model("div_rand", 1'b1, $urandom, $urandom_range(1, 1 << 20) * (i[0] ? -1 : 1));
      end
      run_model("div_small", 1'b1, 32'd3, 32'hFFFF_FFF6);

      // Abort a divide mid-flight
      @(negedge clk);
      start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_dz",   64'(div_zero), 64'(0));
      chk("rst_hi",   64'(hi), 64'(0));
      chk("rst_lo",   64'(lo), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      prev_hi = '0;
      prev_lo = '0;
      run_op("div_after_rst", 1'b1, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 34, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
